// File: rtl/ysyx_22050598_wb_arbiter_if.sv
// ysyx_22050598_wb_arbiter_if
//   Bundles every signal that connects the writeback arbiter to its neighbours:
//   LS/WB writeback request, MDU issue/result handshake, decode hazard query,
//   and the register-file write port.
//   modport slave  : the arbiter's view (consumes requests, drives rf/hazard/stall).
//   modport master : the surrounding pipeline's view (drives requests, observes results).
interface ysyx_22050598_wb_arbiter_if #(
  parameter int XLEN = 64
);
  // LS/WB writeback
  logic            pipe_rd_en;
  logic [4:0]      pipe_rd_idx;
  logic [XLEN-1:0] pipe_rd_data;
  logic            pipe_ebreak;
  // MDU issue and result
  logic            mdu_issue;
  logic [4:0]      mdu_issue_idx;
  logic            mdu_valid;
  logic            mdu_ready;
  logic [4:0]      mdu_rd_idx;
  logic [XLEN-1:0] mdu_rd_data;
  // decode hazard query
  logic [4:0]      dec_rs1_idx;
  logic [4:0]      dec_rs2_idx;
  logic [4:0]      dec_rd_idx;
  logic            raw_hazard;
  // writeback control and regfile port
  logic            wb_stall;
  logic            rf_wen;
  logic [4:0]      rf_widx;
  logic [XLEN-1:0] rf_wdata;
  logic            halt;

  modport slave (
    input  pipe_rd_en, pipe_rd_idx, pipe_rd_data, pipe_ebreak,
    input  mdu_issue, mdu_issue_idx, mdu_valid, mdu_rd_idx, mdu_rd_data,
    input  dec_rs1_idx, dec_rs2_idx, dec_rd_idx,
    output mdu_ready, raw_hazard, wb_stall, rf_wen, rf_widx, rf_wdata, halt
  );

  modport master (
    output pipe_rd_en, pipe_rd_idx, pipe_rd_data, pipe_ebreak,
    output mdu_issue, mdu_issue_idx, mdu_valid, mdu_rd_idx, mdu_rd_data,
    output dec_rs1_idx, dec_rs2_idx, dec_rd_idx,
    input  mdu_ready, raw_hazard, wb_stall, rf_wen, rf_widx, rf_wdata, halt
  );
endinterface

// File: rtl/ysyx_22050598_wb_arbiter.sv
// ysyx_22050598_wb_arbiter
//   Shares the single regfile write port between the in-order LS/WB stage and
//   the out-of-band MDU result path. One MDU result is held in a skid buffer;
//   the pipeline normally wins the port, but once the buffered result has lost
//   MAX_WAIT times, wb_stall freezes LS/WB for a cycle so the buffer drains.
//   A pending scoreboard of MDU destinations feeds decode's RAW/WAW stall, and
//   a sticky halt flag records ebreak retirement.
// Ports
//   clk  : clock, all state updates on the rising edge
//   rst  : asynchronous active-low reset
//   bus  : slave modport (LS/WB request, MDU handshake, decode query,
//          regfile write port, wb_stall, halt)
module ysyx_22050598_wb_arbiter #(
  parameter int XLEN     = 64,
  parameter int MAX_WAIT = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  ysyx_22050598_wb_arbiter_if.slave    bus
);

  localparam int WW = $clog2(MAX_WAIT + 1);
  localparam logic [WW-1:0] WAIT_MAX = WW'(MAX_WAIT);

  typedef struct packed {
    logic [4:0]      idx;
    logic [XLEN-1:0] data;
  } mdu_ent_t;

  // ---------------------------------------------------------------------------
  // state
  // ---------------------------------------------------------------------------
  logic            buf_vld;
  mdu_ent_t        buf_q;
  logic [WW-1:0]   wait_cnt;
  logic [31:1]     pend_q;
  logic            halt_q;

  // x0 slot is hard-wired clear so indexing by a raw 5-bit register id is safe
  logic [31:0]     pend_vec;
  assign pend_vec = {pend_q, 1'b0};

  // ---------------------------------------------------------------------------
  // grant
  // ---------------------------------------------------------------------------
  logic wb_stall;
  logic pipe_req;
  logic buf_wr;   // buffer owns the port this cycle (drains even if idx==0)
  logic pipe_wr;
  logic buf_lose;

  assign wb_stall = buf_vld & (wait_cnt >= WAIT_MAX);
  assign pipe_req = bus.pipe_rd_en & (bus.pipe_rd_idx != 5'd0);
  // A pipe write to x0 is a non-request, so the buffer takes the slot.
  assign buf_wr   = buf_vld & (wb_stall | ~pipe_req);
  assign pipe_wr  = pipe_req & ~wb_stall;
  assign buf_lose = buf_vld & ~buf_wr;

  always_comb begin
    bus.rf_wen   = 1'b0;
    bus.rf_widx  = 5'd0;
    bus.rf_wdata = '0;
    if (buf_wr) begin
      // An MDU result aimed at x0 still drains the buffer, just without a write.
      if (buf_q.idx != 5'd0) begin
        bus.rf_wen   = 1'b1;
        bus.rf_widx  = buf_q.idx;
        bus.rf_wdata = buf_q.data;
      end
    end else if (pipe_wr) begin
      bus.rf_wen   = 1'b1;
      bus.rf_widx  = bus.pipe_rd_idx;
      bus.rf_wdata = bus.pipe_rd_data;
    end
  end

  assign bus.wb_stall   = wb_stall;
  // No same-cycle drain and refill: a buffer freed this cycle reopens next cycle.
  assign bus.mdu_ready  = ~buf_vld;
  assign bus.raw_hazard = pend_vec[bus.dec_rs1_idx]
                        | pend_vec[bus.dec_rs2_idx]
                        | pend_vec[bus.dec_rd_idx];
  assign bus.halt       = halt_q;

  // ---------------------------------------------------------------------------
  // skid buffer and wait counter
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      buf_vld  <= 1'b0;
      buf_q    <= '0;
      wait_cnt <= '0;
    end else begin
      if (buf_wr) begin
        buf_vld  <= 1'b0;
        wait_cnt <= '0;
      end else if (buf_lose && (wait_cnt < WAIT_MAX)) begin
        wait_cnt <= wait_cnt + WW'(1);
      end
      // mdu_ready implies buf_vld==0, so this never collides with a drain.
      if (bus.mdu_valid && !buf_vld) begin
        buf_vld    <= 1'b1;
        buf_q.idx  <= bus.mdu_rd_idx;
        buf_q.data <= bus.mdu_rd_data;
        wait_cnt   <= '0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // pending-destination scoreboard, one flop per architectural register
  // ---------------------------------------------------------------------------
  for (genvar i = 1; i < 32; i++) begin : g_pend
    logic set_i;
    logic clr_i;
    assign set_i = bus.mdu_issue & (bus.mdu_issue_idx == 5'(i));
    assign clr_i = buf_wr & (buf_q.idx == 5'(i));

    // A new issue to a register retiring on the same edge must stay pending.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst)       pend_q[i] <= 1'b0;
      else if (set_i) pend_q[i] <= 1'b1;
      else if (clr_i) pend_q[i] <= 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // sticky halt: an ebreak held by wb_stall has not retired yet
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                halt_q <= 1'b0;
    else if (bus.pipe_ebreak && !wb_stall)   halt_q <= 1'b1;
  end

endmodule

// File: tb/tb_ysyx_22050598_wb_arbiter.sv
module tb_ysyx_22050598_wb_arbiter;
  localparam int XLEN     = 64;
  localparam int MAX_WAIT = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  ysyx_22050598_wb_arbiter_if #(.XLEN(XLEN)) bus();

  ysyx_22050598_wb_arbiter #(.XLEN(XLEN), .MAX_WAIT(MAX_WAIT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_cmp = 0;
  int n_err = 0;

  // ---------------------------------------------------------------------------
  // reference model: a depth-1 result queue, a loss counter, a set of pending
  // registers and a halt flag, advanced once per clock from the port rules
  // ---------------------------------------------------------------------------
  typedef struct {
    logic [4:0]      idx;
    logic [XLEN-1:0] data;
  } ent_t;

  ent_t            mq[$];
  int              m_loss;
  bit              m_pend[32];
  bit              m_halt;

  bit              e_ready, e_stall, e_wen, e_haz;
  logic [4:0]      e_widx;
  logic [XLEN-1:0] e_wdata;
  int              e_src; // 0 none, 1 pipe, 2 buffer

  function automatic void model_reset();
    mq.delete();
    m_loss = 0;
    foreach (m_pend[i]) m_pend[i] = 1'b0;
    m_halt = 1'b0;
  endfunction

  function automatic bit pend_of(logic [4:0] r);
    return (r != 0) && m_pend[r];
  endfunction

  function automatic void model_expect();
    bit pipe_real;
    e_ready   = (mq.size() == 0);
    e_stall   = (mq.size() != 0) && (m_loss >= MAX_WAIT);
    pipe_real = bus.pipe_rd_en && (bus.pipe_rd_idx != 0);
    if (e_stall)              e_src = 2;
    else if (pipe_real)       e_src = 1;
    else if (mq.size() != 0)  e_src = 2;
    else                      e_src = 0;
    e_wen = 0; e_widx = 0; e_wdata = 0;
    if (e_src == 1) begin
      e_wen = 1; e_widx = bus.pipe_rd_idx; e_wdata = bus.pipe_rd_data;
    end else if (e_src == 2 && mq[0].idx != 0) begin
      e_wen = 1; e_widx = mq[0].idx; e_wdata = mq[0].data;
    end
    e_haz = pend_of(bus.dec_rs1_idx) || pend_of(bus.dec_rs2_idx) || pend_of(bus.dec_rd_idx);
  endfunction

  function automatic void model_commit();
    ent_t e;
    model_expect();
    if (bus.pipe_ebreak && !e_stall) m_halt = 1'b1;
    if (e_src == 2) begin
      e = mq.pop_front();
      m_pend[e.idx] = 1'b0;
      m_loss = 0;
    end else if (mq.size() != 0) begin
      m_loss = (m_loss + 1 > MAX_WAIT) ? MAX_WAIT : m_loss + 1;
    end
    if (bus.mdu_issue && bus.mdu_issue_idx != 0) m_pend[bus.mdu_issue_idx] = 1'b1;
    if (e_ready && bus.mdu_valid) begin
      e.idx = bus.mdu_rd_idx; e.data = bus.mdu_rd_data;
      mq.push_back(e);
      m_loss = 0;
    end
  endfunction

  // advance one clock: model follows the DUT's edge, then inputs may change
  task automatic adv();
    if (!rst) model_reset();
    else      model_commit();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.pipe_rd_en = 0; bus.pipe_rd_idx = 0; bus.pipe_rd_data = 0; bus.pipe_ebreak = 0;
    bus.mdu_issue = 0; bus.mdu_issue_idx = 0; bus.mdu_valid = 0; bus.mdu_rd_idx = 0;
    bus.mdu_rd_data = 0; bus.dec_rs1_idx = 0; bus.dec_rs2_idx = 0; bus.dec_rd_idx = 0;
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset();
    idle();
    model_reset();
    #3;
    n_cmp++; if (bus.mdu_ready !== 1'b1)  begin n_err++; $display("FAIL reset_ready got %b exp 1", bus.mdu_ready); end
    n_cmp++; if (bus.wb_stall !== 1'b0)   begin n_err++; $display("FAIL reset_stall got %b exp 0", bus.wb_stall); end
    n_cmp++; if (bus.rf_wen !== 1'b0)     begin n_err++; $display("FAIL reset_wen got %b exp 0", bus.rf_wen); end
    n_cmp++; if (bus.raw_hazard !== 1'b0) begin n_err++; $display("FAIL reset_haz got %b exp 0", bus.raw_hazard); end
    n_cmp++; if (bus.halt !== 1'b0)       begin n_err++; $display("FAIL reset_halt got %b exp 0", bus.halt); end
    @(posedge clk); #1;
    rst = 1'b1;
  endtask

  task automatic test_pipe_write();
    idle();
    bus.pipe_rd_en = 1; bus.pipe_rd_idx = 5; bus.pipe_rd_data = 64'hAA;
    #4;
    n_cmp++; if (bus.rf_wen !== 1'b1)    begin n_err++; $display("FAIL t1_wen got %b exp 1", bus.rf_wen); end
    n_cmp++; if (bus.rf_widx !== 5'd5)   begin n_err++; $display("FAIL t1_widx got %0d exp 5", bus.rf_widx); end
    n_cmp++; if (bus.rf_wdata !== 64'hAA) begin n_err++; $display("FAIL t1_wdata got %h exp aa", bus.rf_wdata); end
    n_cmp++; if (bus.wb_stall !== 1'b0)  begin n_err++; $display("FAIL t1_stall got %b exp 0", bus.wb_stall); end
    adv();
  endtask

  task automatic test_mdu_hazard();
    idle();
    bus.mdu_issue = 1; bus.mdu_issue_idx = 7;
    adv();
    idle();
    bus.dec_rs1_idx = 7;
    bus.mdu_valid = 1; bus.mdu_rd_idx = 7; bus.mdu_rd_data = 64'h1234;
    #4;
    n_cmp++; if (bus.raw_hazard !== 1'b1) begin n_err++; $display("FAIL t2_haz_set got %b exp 1", bus.raw_hazard); end
    n_cmp++; if (bus.mdu_ready !== 1'b1)  begin n_err++; $display("FAIL t2_ready got %b exp 1", bus.mdu_ready); end
    adv();
    bus.mdu_valid = 0;
    #4;
    n_cmp++; if (bus.rf_wen !== 1'b1)      begin n_err++; $display("FAIL t2_wen got %b exp 1", bus.rf_wen); end
    n_cmp++; if (bus.rf_widx !== 5'd7)     begin n_err++; $display("FAIL t2_widx got %0d exp 7", bus.rf_widx); end
    n_cmp++; if (bus.rf_wdata !== 64'h1234) begin n_err++; $display("FAIL t2_wdata got %h exp 1234", bus.rf_wdata); end
    n_cmp++; if (bus.mdu_ready !== 1'b0)   begin n_err++; $display("FAIL t2_busy got %b exp 0", bus.mdu_ready); end
    adv();
    #4;
    n_cmp++; if (bus.raw_hazard !== 1'b0) begin n_err++; $display("FAIL t2_haz_clr got %b exp 0", bus.raw_hazard); end
    n_cmp++; if (bus.mdu_ready !== 1'b1)  begin n_err++; $display("FAIL t2_ready2 got %b exp 1", bus.mdu_ready); end
    n_cmp++; if (bus.rf_wen !== 1'b0)     begin n_err++; $display("FAIL t2_idle got %b exp 0", bus.rf_wen); end
    adv();
  endtask

  task automatic test_back_to_back();
    idle();
    bus.mdu_issue = 1; bus.mdu_issue_idx = 20;
    bus.mdu_valid = 1; bus.mdu_rd_idx = 20; bus.mdu_rd_data = 64'hBEEF;
    adv();
    for (int k = 1; k <= 3; k++) begin
      idle();
      bus.pipe_rd_en = 1; bus.pipe_rd_idx = 5'(k); bus.pipe_rd_data = 64'(k * 'h101);
      #4;
      if (k < 3) begin
        n_cmp++; if (bus.wb_stall !== 1'b0)  begin n_err++; $display("FAIL t3_nostall%0d got %b exp 0", k, bus.wb_stall); end
        n_cmp++; if (bus.rf_widx !== 5'(k))  begin n_err++; $display("FAIL t3_pipe%0d got %0d exp %0d", k, bus.rf_widx, k); end
      end else begin
        n_cmp++; if (bus.wb_stall !== 1'b1)  begin n_err++; $display("FAIL t3_stall got %b exp 1", bus.wb_stall); end
        n_cmp++; if (bus.rf_widx !== 5'd20 || bus.rf_wdata !== 64'hBEEF)
          begin n_err++; $display("FAIL t3_bufwr got %0d/%h exp 20/beef", bus.rf_widx, bus.rf_wdata); end
      end
      adv();
    end
    #4;
    n_cmp++; if (bus.wb_stall !== 1'b0) begin n_err++; $display("FAIL t3_release got %b exp 0", bus.wb_stall); end
    n_cmp++; if (bus.rf_wen !== 1'b1 || bus.rf_widx !== 5'd3 || bus.rf_wdata !== 64'h303)
      begin n_err++; $display("FAIL t3_held got %b/%0d/%h exp 1/3/303", bus.rf_wen, bus.rf_widx, bus.rf_wdata); end
    adv();
  endtask

  task automatic test_x0();
    idle();
    bus.mdu_issue = 1; bus.mdu_issue_idx = 0;
    bus.mdu_valid = 1; bus.mdu_rd_idx = 11; bus.mdu_rd_data = 64'h55;
    adv();
    idle();
    bus.pipe_rd_en = 1; bus.pipe_rd_idx = 0; bus.pipe_rd_data = 64'hDEAD;
    #4;
    n_cmp++; if (bus.rf_wen !== 1'b1 || bus.rf_widx !== 5'd11 || bus.rf_wdata !== 64'h55)
      begin n_err++; $display("FAIL t4_drain got %b/%0d/%h exp 1/11/55", bus.rf_wen, bus.rf_widx, bus.rf_wdata); end
    n_cmp++; if (bus.raw_hazard !== 1'b0) begin n_err++; $display("FAIL t4_x0pend got %b exp 0", bus.raw_hazard); end
    adv();
    // MDU result aimed at x0: drains without a write
    idle();
    bus.mdu_valid = 1; bus.mdu_rd_idx = 0; bus.mdu_rd_data = 64'h77;
    adv();
    idle();
    #4;
    n_cmp++; if (bus.rf_wen !== 1'b0)    begin n_err++; $display("FAIL t4_nox0 got %b exp 0", bus.rf_wen); end
    n_cmp++; if (bus.mdu_ready !== 1'b0) begin n_err++; $display("FAIL t4_x0buf got %b exp 0", bus.mdu_ready); end
    adv();
    #4;
    n_cmp++; if (bus.mdu_ready !== 1'b1) begin n_err++; $display("FAIL t4_x0free got %b exp 1", bus.mdu_ready); end
    adv();
  endtask

  task automatic test_halt();
    idle();
    bus.mdu_valid = 1; bus.mdu_rd_idx = 13; bus.mdu_rd_data = 64'h13;
    adv();
    for (int k = 0; k < 2; k++) begin
      idle(); bus.pipe_rd_en = 1; bus.pipe_rd_idx = 1;
      adv();
    end
    idle();
    bus.pipe_rd_en = 1; bus.pipe_rd_idx = 4; bus.pipe_ebreak = 1;
    #4;
    n_cmp++; if (bus.wb_stall !== 1'b1) begin n_err++; $display("FAIL t5_stall got %b exp 1", bus.wb_stall); end
    adv();
    #4;
    n_cmp++; if (bus.halt !== 1'b0) begin n_err++; $display("FAIL t5_stalled_ebreak got %b exp 0", bus.halt); end
    adv();
    idle();
    for (int k = 0; k < 10; k++) begin
      #4;
      n_cmp++; if (bus.halt !== 1'b1) begin n_err++; $display("FAIL t5_sticky%0d got %b exp 1", k, bus.halt); end
      adv();
    end
  endtask

  task automatic test_async_reset();
    idle();
    bus.mdu_issue = 1; bus.mdu_issue_idx = 9;
    bus.mdu_valid = 1; bus.mdu_rd_idx = 12; bus.mdu_rd_data = 64'h12;
    adv();
    idle();
    bus.dec_rs1_idx = 9;
    bus.pipe_rd_en = 1; bus.pipe_rd_idx = 3;
    #2;
    n_cmp++; if (bus.raw_hazard !== 1'b1 || bus.mdu_ready !== 1'b0)
      begin n_err++; $display("FAIL t6_pre got %b/%b exp 1/0", bus.raw_hazard, bus.mdu_ready); end
    bus.pipe_rd_en = 0;
    rst = 1'b0;
    #1;
    n_cmp++; if (bus.mdu_ready !== 1'b1)  begin n_err++; $display("FAIL t6_ready got %b exp 1", bus.mdu_ready); end
    n_cmp++; if (bus.raw_hazard !== 1'b0) begin n_err++; $display("FAIL t6_haz got %b exp 0", bus.raw_hazard); end
    n_cmp++; if (bus.rf_wen !== 1'b0)     begin n_err++; $display("FAIL t6_wen got %b exp 0", bus.rf_wen); end
    n_cmp++; if (bus.halt !== 1'b0)       begin n_err++; $display("FAIL t6_halt got %b exp 0", bus.halt); end
    model_reset();
    @(posedge clk); #1;
    rst = 1'b1;
  endtask

  task automatic test_random();
    for (int c = 0; c < 2000; c++) begin
      bit do_rst;
      do_rst = ($urandom_range(0, 299) == 0);
      bus.pipe_rd_en    = ($urandom_range(0, 9) < 6);
      bus.pipe_rd_idx   = 5'($urandom_range(0, 7));
      bus.pipe_rd_data  = {$urandom, $urandom};
      bus.pipe_ebreak   = ($urandom_range(0, 49) == 0);
      bus.mdu_issue     = ($urandom_range(0, 3) == 0);
      bus.mdu_issue_idx = 5'($urandom_range(0, 7));
      bus.mdu_valid     = ($urandom_range(0, 9) < 3);
      bus.mdu_rd_idx    = 5'($urandom_range(0, 7));
      bus.mdu_rd_data   = {$urandom, $urandom};
      bus.dec_rs1_idx   = 5'($urandom_range(0, 7));
      bus.dec_rs2_idx   = 5'($urandom_range(0, 7));
      bus.dec_rd_idx    = 5'($urandom_range(0, 7));
      if (do_rst) begin rst = 1'b0; model_reset(); end
      #4;
      model_expect();
      n_cmp++; if (bus.mdu_ready !== e_ready) begin n_err++; $display("FAIL rnd%0d_ready got %b exp %b", c, bus.mdu_ready, e_ready); end
      n_cmp++; if (bus.wb_stall !== e_stall)  begin n_err++; $display("FAIL rnd%0d_stall got %b exp %b", c, bus.wb_stall, e_stall); end
      n_cmp++; if (bus.rf_wen !== e_wen)      begin n_err++; $display("FAIL rnd%0d_wen got %b exp %b", c, bus.rf_wen, e_wen); end
      n_cmp++; if (bus.rf_widx !== e_widx)    begin n_err++; $display("FAIL rnd%0d_widx got %0d exp %0d", c, bus.rf_widx, e_widx); end
      n_cmp++; if (bus.rf_wdata !== e_wdata)  begin n_err++; $display("FAIL rnd%0d_wdata got %h exp %h", c, bus.rf_wdata, e_wdata); end
      n_cmp++; if (bus.raw_hazard !== e_haz)  begin n_err++; $display("FAIL rnd%0d_haz got %b exp %b", c, bus.raw_hazard, e_haz); end
      n_cmp++; if (bus.halt !== m_halt)       begin n_err++; $display("FAIL rnd%0d_halt got %b exp %b", c, bus.halt, m_halt); end
      adv();
      if (do_rst) rst = 1'b1;
    end
  endtask

  initial begin
    test_reset();
    test_pipe_write();
    test_mdu_hazard();
    test_back_to_back();
    test_x0();
    test_halt();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
